keypad_scanner: RTL and testbench

Scans a 4x4 matrix keypad by driving one active-low column at a time. It watches the row lines, which arrive already passed through the per-row two-flop synchronizers, and debounces both press and release. It emits one `key_valid` pulse with a 4-bit hex code per physical keypress. It sits between the synchronizer bank and the display/key-history logic of the lab3 top level, and is the only block that sequences column drive relative to synchronizer latency.

---
 rtl/keypad_pkg.sv | 53 +++++
 rtl/stable_counter.sv | 38 +++
 rtl/keypad_scanner.sv | 139 +++++++++++++
 tb/tb_keypad_scanner.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// Shared types and helpers for the 4x4 keypad scanner: FSM states, settle delay,
// key map and row-pattern decoding.
package keypad_pkg;

    typedef enum logic [1:0] {
        SCAN,
        DEB_PRESS,
        HELD,
        DEB_RELEASE
    } scan_state_t;

    // Synchronizer latency seen on rows_n after each column change.
    localparam int SETTLE_CYCLES = 2;

    function automatic logic [3:0] key_map(input logic [1:0] row, input logic [1:0] col);
        logic [3:0] code;
        case ({row, col})
            4'h0: code = 4'h1;
            4'h1: code = 4'h2;
            4'h2: code = 4'h3;
            4'h3: code = 4'hA;
            4'h4: code = 4'h4;
            4'h5: code = 4'h5;
            4'h6: code = 4'h6;
            4'h7: code = 4'hB;
            4'h8: code = 4'h7;
            4'h9: code = 4'h8;
            4'hA: code = 4'h9;
            4'hB: code = 4'hC;
            4'hC: code = 4'hE;
            4'hD: code = 4'h0;
            4'hE: code = 4'hF;
            default: code = 4'hD;
        endcase
        return code;
    endfunction

    function automatic logic single_low(input logic [3:0] rows_n);
        logic [3:0] low;
        low = ~rows_n;
        return (low != 4'h0) && ((low & (low - 4'h1)) == 4'h0);
    endfunction

    function automatic logic [1:0] low_row(input logic [3:0] rows_n);
        logic [1:0] idx;
        idx = 2'd0;
        for (int r = 3; r >= 0; r--) begin
            if (!rows_n[r]) idx = 2'(r);
        end
        return idx;
    endfunction

endpackage

// File: rtl/stable_counter.sv
// Cycle counter that advances while match_i holds and flags the cycle in which
// the run reaches term_i; it saturates at term_i instead of wrapping.
module stable_counter #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr_i,
    input  logic             match_i,
    input  logic [CNT_W-1:0] term_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             done_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (match_i && (cnt_q != term_i)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o  = cnt_q;
    assign done_o = match_i && (cnt_q == term_i - 1'b1);

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner: walks an active-low column, debounces press and release on
// the synchronized rows, and emits one key_valid pulse per physical keypress.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_CYCLES     = 1000,
    parameter int DEBOUNCE_CYCLES = 20000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] rows_n,
    output logic [3:0] cols_n,
    output logic       key_valid,
    output logic [3:0] key_code,
    output logic       key_held
);

    localparam int CNT_MAX = (SCAN_CYCLES > DEBOUNCE_CYCLES) ? SCAN_CYCLES : DEBOUNCE_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] SETTLE_C = CNT_W'(SETTLE_CYCLES);
    localparam logic [CNT_W-1:0] SCAN_C   = CNT_W'(SCAN_CYCLES);
    localparam logic [CNT_W-1:0] DEB_C    = CNT_W'(DEBOUNCE_CYCLES);

    scan_state_t      state_q;
    logic [1:0]       col_q;
    logic [1:0]       row_q;
    logic [3:0]       cols_n_q;
    logic             key_valid_q;
    logic [3:0]       key_code_q;
    logic             key_held_q;

    logic [CNT_W-1:0] cnt;
    logic             cnt_done;
    logic             cnt_match;
    logic             cnt_clr;
    logic [CNT_W-1:0] cnt_term;
    logic             capture;
    logic [3:0]       next_cols_n;

    // SCAN counts every cycle against the column period; debounce phases count
    // only while the captured row reads the expected level.
    always_comb begin
        cnt_match = 1'b1;
        cnt_term  = SCAN_C;
        capture   = (cnt >= SETTLE_C) && single_low(rows_n);
        unique case (state_q)
            SCAN: begin
                cnt_match = 1'b1;
                cnt_term  = SCAN_C;
            end
            DEB_PRESS: begin
                cnt_match = (rows_n == ~(4'b0001 << row_q));
                cnt_term  = DEB_C;
            end
            HELD: begin
                cnt_match = 1'b0;
                cnt_term  = DEB_C;
            end
            DEB_RELEASE: begin
                cnt_match = rows_n[row_q];
                cnt_term  = DEB_C;
            end
            default: begin
                cnt_match = 1'b0;
                cnt_term  = DEB_C;
            end
        endcase
    end

    assign cnt_clr     = !cnt_match || cnt_done || ((state_q == SCAN) && capture);
    assign next_cols_n = ~(4'b0001 << (col_q + 2'd1));

    stable_counter #(
        .CNT_W(CNT_W)
    ) u_cnt (
        .clk    (clk),
        .reset  (reset),
        .clr_i  (cnt_clr),
        .match_i(cnt_match),
        .term_i (cnt_term),
        .cnt_o  (cnt),
        .done_o (cnt_done)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= SCAN;
            col_q       <= 2'd0;
            row_q       <= 2'd0;
            cols_n_q    <= 4'b1110;
            key_valid_q <= 1'b0;
            key_code_q  <= 4'h0;
            key_held_q  <= 1'b0;
        end else begin
            key_valid_q <= 1'b0;
            unique case (state_q)
                SCAN: begin
                    if (capture) begin
                        row_q   <= low_row(rows_n);
                        state_q <= DEB_PRESS;
                    end else if (cnt_done) begin
                        col_q    <= col_q + 2'd1;
                        cols_n_q <= next_cols_n;
                    end
                end
                DEB_PRESS: begin
                    if (!cnt_match) begin
                        state_q <= SCAN;
                    end else if (cnt_done) begin
                        key_valid_q <= 1'b1;
                        key_code_q  <= key_map(row_q, col_q);
                        key_held_q  <= 1'b1;
                        state_q     <= HELD;
                    end
                end
                HELD: begin
                    if (rows_n[row_q]) state_q <= DEB_RELEASE;
                end
                DEB_RELEASE: begin
                    if (!cnt_match) begin
                        state_q <= HELD;
                    end else if (cnt_done) begin
                        key_held_q <= 1'b0;
                        col_q      <= col_q + 2'd1;
                        cols_n_q   <= next_cols_n;
                        state_q    <= SCAN;
                    end
                end
                default: state_q <= SCAN;
            endcase
        end
    end

    assign cols_n    = cols_n_q;
    assign key_valid = key_valid_q;
    assign key_code  = key_code_q;
    assign key_held  = key_held_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: a physical key-matrix model drives rows_n from the
// driven column, and expected outputs come from the keypad's timing rules.
module tb_keypad_scanner;

    localparam int SCAN   = 8;
    localparam int DEB    = 4;
    localparam int SETTLE = 2;
    localparam logic [3:0] KMAP [16] = '{4'h1, 4'h2, 4'h3, 4'hA,
                                         4'h4, 4'h5, 4'h6, 4'hB,
                                         4'h7, 4'h8, 4'h9, 4'hC,
                                         4'hE, 4'h0, 4'hF, 4'hD};

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  rows_n;
    logic [3:0]  cols_n;
    logic        key_valid;
    logic [3:0]  key_code;
    logic        key_held;
    logic [15:0] pressed = '0;   // bit r*4+c = key at row r, column c is down

    int checks = 0;
    int passed = 0;

    always #5 clk = ~clk;

    // A row reads low only when a pressed key on it sits in a driven column.
    always_comb begin
        rows_n = 4'hF;
        for (int r = 0; r < 4; r++) begin
            if (|(pressed[r*4 +: 4] & ~cols_n)) rows_n[r] = 1'b0;
        end
    end

    keypad_scanner #(
        .SCAN_CYCLES    (SCAN),
        .DEBOUNCE_CYCLES(DEB)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .rows_n   (rows_n),
        .cols_n   (cols_n),
        .key_valid(key_valid),
        .key_code (key_code),
        .key_held (key_held)
    );

    function automatic logic [3:0] col_drive(input int c);
        return ~(4'b0001 << (c % 4));
    endfunction

    function automatic logic [3:0] walk(input int j);
        return col_drive(j / SCAN);
    endfunction

    // Leaves the bench at the falling edge of cycle 0 (first cycle out of reset).
    task automatic do_reset;
        @(negedge clk);
        reset   = 1'b1;
        pressed = '0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset;
        do_reset();
        checks++;
        if (cols_n !== 4'b1110) $display("FAIL reset_cols got %b expected 1110", cols_n);
        else passed++;
        checks++;
        if (key_valid !== 1'b0) $display("FAIL reset_valid got %b expected 0", key_valid);
        else passed++;
        checks++;
        if (key_code !== 4'h0) $display("FAIL reset_code got %h expected 0", key_code);
        else passed++;
        checks++;
        if (key_held !== 1'b0) $display("FAIL reset_held got %b expected 0", key_held);
        else passed++;
    endtask

    task automatic test_idle_scan;
        do_reset();
        for (int j = 0; j <= 40; j++) begin
            checks++;
            if ({cols_n, key_valid} !== {walk(j), 1'b0})
                $display("FAIL idle_scan cycle %0d: got cols=%b v=%b, expected cols=%b v=0",
                         j, cols_n, key_valid, walk(j));
            else passed++;
            @(negedge clk);
        end
    endtask

    // Key held from cycle 0, released `hold` cycles after its pulse.
    task automatic test_press(input int r, input int c, input int hold, input string name);
        int t_det, tp, tr, tf;
        logic e_v, e_h;
        logic [3:0] e_code, e_cols;
        t_det = SCAN * c + SETTLE;
        tp    = t_det + DEB + 1;
        tr    = tp + hold;
        tf    = tr + DEB + 1;
        do_reset();
        for (int j = 0; j <= tf + 20; j++) begin
            if (j == 0)  pressed[r*4 + c] = 1'b1;
            if (j == tr) pressed[r*4 + c] = 1'b0;
            e_v    = (j == tp);
            e_h    = (j >= tp) && (j < tf);
            e_code = (j >= tp) ? KMAP[r*4 + c] : 4'h0;
            e_cols = (j < SCAN * c) ? walk(j) :
                     (j < tf) ? col_drive(c) : col_drive(c + 1 + (j - tf) / SCAN);
            checks++;
            if ({key_valid, key_held, key_code, cols_n} !== {e_v, e_h, e_code, e_cols})
                $display("FAIL %s r%0d c%0d cycle %0d: got v=%b h=%b code=%h cols=%b, expected v=%b h=%b code=%h cols=%b",
                         name, r, c, j, key_valid, key_held, key_code, cols_n, e_v, e_h, e_code, e_cols);
            else passed++;
            @(negedge clk);
        end
    endtask

    task automatic test_press_six;
        test_press(1, 2, 10, "press6");
    endtask

    task automatic test_random_press;
        for (int i = 0; i < 6; i++) begin
            test_press(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                       int'($urandom_range(1, 12)), "random_press");
        end
    endtask

    // Bounce low/high/low/high from cycle 18; stable low from 22. The failed
    // debounce restarts SCAN on column 2 at 20, settles at 22, pulses at 27.
    task automatic test_bounce;
        logic e_v;
        logic [3:0] e_code;
        do_reset();
        for (int j = 0; j <= 36; j++) begin
            pressed[6] = (j == 18) || (j == 20) || (j >= 22);
            e_v    = (j == 27);
            e_code = (j >= 27) ? 4'h6 : 4'h0;
            checks++;
            if ({key_valid, key_code} !== {e_v, e_code})
                $display("FAIL bounce cycle %0d: got v=%b code=%h, expected v=%b code=%h",
                         j, key_valid, key_code, e_v, e_code);
            else passed++;
            @(negedge clk);
        end
    endtask

    // "6" pulses at 23; "A" pressed at 26 is ignored; "6" released at 36, so
    // held falls and column 3 is driven at 41, "A" detected at 43, pulse at 48.
    task automatic test_second_key;
        logic e_v, e_h;
        logic [3:0] e_code, e_cols;
        do_reset();
        for (int j = 0; j <= 56; j++) begin
            pressed[6] = (j < 36);
            pressed[3] = (j >= 26);
            e_v    = (j == 23) || (j == 48);
            e_h    = (j >= 23 && j < 41) || (j >= 48);
            e_code = (j >= 48) ? 4'hA : (j >= 23) ? 4'h6 : 4'h0;
            e_cols = (j < 16) ? walk(j) : (j < 41) ? 4'b1011 : 4'b0111;
            checks++;
            if ({key_valid, key_held, key_code, cols_n} !== {e_v, e_h, e_code, e_cols})
                $display("FAIL second_key cycle %0d: got v=%b h=%b code=%h cols=%b, expected v=%b h=%b code=%h cols=%b",
                         j, key_valid, key_held, key_code, cols_n, e_v, e_h, e_code, e_cols);
            else passed++;
            @(negedge clk);
        end
    endtask

    task automatic test_release_glitch;
        logic e_v, e_h;
        logic [3:0] e_cols;
        do_reset();
        for (int j = 0; j <= 45; j++) begin
            pressed[6] = !(j == 28 || j == 29);
            e_v    = (j == 23);
            e_h    = (j >= 23);
            e_cols = (j < 16) ? walk(j) : 4'b1011;
            checks++;
            if ({key_valid, key_held, cols_n} !== {e_v, e_h, e_cols})
                $display("FAIL release_glitch cycle %0d: got v=%b h=%b cols=%b, expected v=%b h=%b cols=%b",
                         j, key_valid, key_held, cols_n, e_v, e_h, e_cols);
            else passed++;
            @(negedge clk);
        end
    endtask

    // "6" is in press debounce during cycles 19..22; reset hits at the end of 20.
    task automatic test_reset_mid;
        do_reset();
        pressed[6] = 1'b1;
        for (int j = 0; j < 20; j++) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if ({cols_n, key_code, key_valid, key_held} !== {4'b1110, 4'h0, 1'b0, 1'b0})
            $display("FAIL reset_mid got cols=%b code=%h v=%b h=%b, expected cols=1110 code=0 v=0 h=0",
                     cols_n, key_code, key_valid, key_held);
        else passed++;
        @(negedge clk);
        reset      = 1'b0;
        pressed[6] = 1'b0;
        for (int j = 0; j < 10; j++) begin
            checks++;
            if ({key_valid, key_held} !== 2'b00)
                $display("FAIL reset_mid_nopulse step %0d: got v=%b h=%b, expected v=0 h=0",
                         j, key_valid, key_held);
            else passed++;
            @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_idle_scan();
        test_press_six();
        test_random_press();
        test_bounce();
        test_second_key();
        test_release_glitch();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
